mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 4, max accepted beats per grant before forced hand-over when the other requester is waiting (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  request from source 0 / source 1.
REQ-005 in0, in1  input  1 each  data bits from source 0 / source 1.
REQ-006 out_ready  input  1  downstream can accept out this cycle.
REQ-007 sel  output  1  select driven to the downstream 2:1 mux; 0 = source 0, 1 = source 1.
REQ-008 gnt0, gnt1  output  1 each  grant to source 0 / source 1; never both high.
REQ-009 out  output  1  registered selected data bit.
REQ-010 out_valid  output  1  out holds an unconsumed beat.

Function
REQ-011 Three-state FSM: IDLE, GRANT0, GRANT1; internal last-served flag and 8-bit beat counter cnt.
REQ-012 gnt0 = (state==GRANT0), gnt1 = (state==GRANT1), sel = (state==GRANT1); all decoded from registered state, no combinational path from inputs.
REQ-013 IDLE: req0 only -> GRANT0; req1 only -> GRANT1; both -> source not last served; none -> stay IDLE.
REQ-014 Beat accept in GRANTx when req_x=1 and (out_valid=0 or out_ready=1): out <= in_x, out_valid <= 1, cnt <= cnt+1.
REQ-015 out_valid=1 and out_ready=1 with no accept in same cycle -> out_valid <= 0; out holds last value.
REQ-016 out_valid=1 and out_ready=0 -> out, out_valid, cnt, state all hold (stall); grant stays.
REQ-017 GRANTx with req_x=0 -> IDLE next cycle, last <= x, cnt <= 0; no beat accepted that cycle.
REQ-018 Accept that brings cnt to HOLD_MAX while other request high -> GRANT(other) next cycle, last <= x, cnt <= 0.
REQ-019 Accept that brings cnt to HOLD_MAX with other request low -> cnt <= 0, stay GRANTx.
REQ-020 Latency: request in IDLE at edge N -> grant visible after edge N+1; first beat on out after edge N+2.
REQ-021 Grant switch is registered: at least one cycle of sel stability per beat; no beat from source x accepted while gnt_x=0.

Reset
REQ-022 rst high: state=IDLE, sel=0, gnt0=0, gnt1=0, out=0, out_valid=0, cnt=0, last=1 (source 0 wins first tie), immediately, independent of clk.
REQ-023 rst asserted mid-grant or mid-stall drops any held beat; first edge after rst release evaluates IDLE rules.

Configuration
REQ-024 Macro ARB_LOCK_EN: when defined, adds input lock (1 bit); while lock=1 in GRANTx with req_x=1, REQ-018 hand-over is suppressed (cnt wraps to 0, grant held).
REQ-025 ARB_LOCK_EN undefined: no lock port; behaviour exactly per REQ-011..REQ-021.

Verification
REQ-026 rst pulse mid-GRANT1 with out_valid=1 -> all outputs 0 asynchronously, last=1; after release req0=req1=1 -> gnt0 first.
REQ-027 req0=1 alone, in0 toggling 1,0,1, out_ready=1 -> gnt0 after 1 edge, out = 1,0,1 on consecutive cycles from edge 2, out_valid=1.
REQ-028 req0=req1=1 constant, HOLD_MAX=4, out_ready=1 -> 4 beats source 0, hand-over, 4 beats source 1, repeating; sel toggles every 4 beats.
REQ-029 GRANT0, out_ready=0 for 3 cycles -> out, out_valid, cnt, gnt0 frozen; beats resume on out_ready=1 with none lost or duplicated.
REQ-030 GRANT1, req1 drops while req0=1 -> IDLE one cycle, then GRANT0; no beat taken from in1 after drop.
REQ-031 ARB_LOCK_EN defined, lock=1, req0=req1=1 in GRANT0 -> gnt0 held past 4 beats; lock=0 -> hand-over at next HOLD_MAX boundary.

Source files
------------

// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - request/grant/data bundle between sources, arbiter and downstream mux
interface mux_sel_arbiter_if;
    logic req0;
    logic req1;
    logic in0;
    logic in1;
    logic out_ready;
`ifdef ARB_LOCK_EN
    logic lock;
`endif
    logic sel;
    logic gnt0;
    logic gnt1;
    logic out;
    logic out_valid;

    modport master (
`ifdef ARB_LOCK_EN
        output lock,
`endif
        output req0, req1, in0, in1, out_ready,
        input  sel, gnt0, gnt1, out, out_valid
    );

    modport slave (
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        input  req0, req1, in0, in1, out_ready,
        output sel, gnt0, gnt1, out, out_valid
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-source round-robin arbiter with beat quota; optional ARB_LOCK_EN adds a quota-override lock input
module mux_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_sel_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [7:0] cnt_inc;
    logic       last;
    logic       last_next;
    logic       out_q;
    logic       out_next;
    logic       valid_q;
    logic       valid_next;
    logic       cur;
    logic       req_cur;
    logic       req_oth;
    logic       in_cur;
    logic       stall;
    logic       lock_on;

`ifdef ARB_LOCK_EN
    assign lock_on = bus.lock;
`else
    assign lock_on = 1'b0;
`endif

    // Current source index and its request/data, plus the other source's request.
    assign cur     = (state == GRANT1);
    assign req_cur = cur ? bus.req1 : bus.req0;
    assign req_oth = cur ? bus.req0 : bus.req1;
    assign in_cur  = cur ? bus.in1  : bus.in0;
    assign stall   = valid_q && !bus.out_ready;
    assign cnt_inc = cnt + 8'd1;

    // Grant and select decode only from registered state.
    assign bus.gnt0      = (state == GRANT0);
    assign bus.gnt1      = (state == GRANT1);
    assign bus.sel       = (state == GRANT1);
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;

    // State, counter, last-served flag and output beat register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            last    <= 1'b1;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            last    <= last_next;
            out_q   <= out_next;
            valid_q <= valid_next;
        end
    end

    // Next-state, quota and beat-accept decisions; a stalled beat freezes everything.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last;
        out_next   = out_q;
        valid_next = valid_q;

        if (valid_q && bus.out_ready) begin
            valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_next = last ? GRANT0 : GRANT1;
                end else if (bus.req0) begin
                    state_next = GRANT0;
                end else if (bus.req1) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (!stall) begin
                    if (!req_cur) begin
                        state_next = IDLE;
                        last_next  = cur;
                        cnt_next   = 8'd0;
                    end else begin
                        out_next   = in_cur;
                        valid_next = 1'b1;
                        if (cnt_inc == HOLD_LIM) begin
                            cnt_next = 8'd0;
                            if (req_oth && !lock_on) begin
                                state_next = cur ? GRANT0 : GRANT1;
                                last_next  = cur;
                            end
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - directed self-checking bench for mux_sel_arbiter
module tb_mux_sel_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.HOLD_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] outs();
        return {bus.sel, bus.gnt0, bus.gnt1, bus.out, bus.out_valid};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.in0 = 1'b0;
        bus.in1 = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        #2;
        check_eq("reset_outputs", 32'(outs()), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // single requester, data 1,0,1
        bus.req0 = 1'b1;
        tick();
        check_eq("single_gnt0", 32'(bus.gnt0), 32'd1);
        check_eq("single_no_beat_yet", 32'(bus.out_valid), 32'd0);
        bus.in0 = 1'b1;
        tick();
        check_eq("single_beat1", 32'({bus.out, bus.out_valid}), 32'b11);
        bus.in0 = 1'b0;
        tick();
        check_eq("single_beat2", 32'({bus.out, bus.out_valid}), 32'b01);
        bus.in0 = 1'b1;
        tick();
        check_eq("single_beat3", 32'({bus.out, bus.out_valid}), 32'b11);
        bus.req0 = 1'b0;
        tick();
        check_eq("single_release", 32'({bus.gnt0, bus.gnt1, bus.out_valid}), 32'b000);

        // grant source 1, then reset asynchronously with a beat held
        bus.req1 = 1'b1;
        bus.in1 = 1'b1;
        tick();
        check_eq("g1_grant", 32'({bus.sel, bus.gnt1}), 32'b11);
        tick();
        check_eq("g1_beat", 32'({bus.out, bus.out_valid}), 32'b11);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_reset", 32'(outs()), 32'd0);
        tick();
        rst = 1'b0;

        // both requesting: source 0 wins the first tie, quota 4 alternates
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.in0 = 1'b1;
        bus.in1 = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            logic g1_exp;
            tick();
            g1_exp = 1'(((e - 1) / 4) % 2);
            check_eq($sformatf("rr_gnt_e%0d", e), 32'({bus.gnt0, bus.gnt1, bus.sel}),
                     32'({~g1_exp, g1_exp, g1_exp}));
            if (e >= 2) begin
                check_eq($sformatf("rr_out_e%0d", e), 32'(bus.out),
                         32'((((e - 2) / 4) % 2) == 0));
            end
        end

        // source 1 drops while source 0 waits: one idle cycle, no stray beat
        bus.req1 = 1'b0;
        bus.in1 = 1'b1;
        bus.in0 = 1'b0;
        tick();
        check_eq("drop_idle", 32'({bus.gnt0, bus.gnt1, bus.out_valid}), 32'b000);
        tick();
        check_eq("drop_then_g0", 32'({bus.gnt0, bus.gnt1, bus.out_valid}), 32'b100);
        tick();
        check_eq("drop_first_beat", 32'({bus.out, bus.out_valid}), 32'b01);

        // stall for 3 cycles, nothing moves
        bus.out_ready = 1'b0;
        bus.in0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("stall_%0d", k), 32'({bus.gnt0, bus.out, bus.out_valid}), 32'b101);
        end
        bus.out_ready = 1'b1;
        tick();
        check_eq("resume_beat", 32'({bus.gnt0, bus.out, bus.out_valid}), 32'b111);
        bus.req1 = 1'b1;
        bus.in0 = 1'b0;
        tick();
        check_eq("resume_cnt3", 32'({bus.gnt0, bus.gnt1, bus.out}), 32'b100);
        tick();
        check_eq("resume_handover", 32'({bus.gnt0, bus.gnt1, bus.out}), 32'b010);

`ifdef ARB_LOCK_EN
        bus.lock = 1'b1;
        bus.in1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq($sformatf("lock_hold_%0d", k), 32'({bus.gnt0, bus.gnt1}), 32'b01);
        end
        bus.lock = 1'b0;
        tick();
        check_eq("unlock_cnt3", 32'({bus.gnt0, bus.gnt1}), 32'b01);
        tick();
        check_eq("unlock_handover", 32'({bus.gnt0, bus.gnt1}), 32'b10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
